// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART receiver: SOF, LEN, LEN payload bytes, XOR checksum.
// One checked packet is held in a small buffer and offered to the host over valid/ready.
module uart_rx_pkt_ctrl #(
  parameter int              SIZE    = 8,
  parameter int              MAX_LEN = 16,
  parameter int              TIMEOUT = 1000,
  parameter logic [SIZE-1:0] SOF     = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_done,
  input  logic [SIZE-1:0]            rx_data,
  output logic                       rx_en,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic [7:0]                 pkt_len,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [SIZE-1:0]            rd_data,
  output logic                       err_chk,
  output logic                       err_len,
  output logic                       err_timeout,
  output logic                       err_ovr
);

  localparam int            AW       = $clog2(MAX_LEN);
  localparam int            TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  localparam int E_CHK = 0;
  localparam int E_LEN = 1;
  localparam int E_TO  = 2;
  localparam int E_OVR = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      len_reg, len_next;
  logic [7:0]      idx_reg, idx_next;
  logic [SIZE-1:0] acc_reg, acc_next;
  logic [TW-1:0]   cnt_reg, cnt_next;
  logic [7:0]      pkt_len_reg, pkt_len_next;
  logic            rx_en_reg;
  logic            pkt_valid_reg;
  logic [3:0]      err_hit, err_reg;
  logic            wr_en;
  logic            len_ok;
  logic            in_frame;

  logic [SIZE-1:0] pay_mem [MAX_LEN];

  assign len_ok   = (rx_data != '0) && (32'(rx_data) <= 32'(MAX_LEN));
  assign in_frame = (state_reg == S_LEN) || (state_reg == S_PAYLOAD) || (state_reg == S_CHK);

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    acc_next     = acc_reg;
    cnt_next     = '0;
    pkt_len_next = pkt_len_reg;
    wr_en        = 1'b0;
    err_hit      = '0;

    case (state_reg)
      S_IDLE: begin
        if (rx_done && (rx_data == SOF)) begin
          state_next = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_done) begin
          if (len_ok) begin
            state_next = S_PAYLOAD;
            len_next   = 8'(rx_data);
            idx_next   = '0;
            acc_next   = rx_data;
          end else begin
            err_hit[E_LEN] = 1'b1;
            state_next     = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        // An SOF value here is ordinary payload; there is no resync mid-frame.
        if (rx_done) begin
          wr_en    = 1'b1;
          acc_next = acc_reg ^ rx_data;
          idx_next = idx_reg + 8'd1;
          if ((idx_reg + 8'd1) == len_reg) begin
            state_next = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (rx_done) begin
          if (rx_data == acc_reg) begin
            state_next   = S_HOLD;
            pkt_len_next = len_reg;
          end else begin
            err_hit[E_CHK] = 1'b1;
            state_next     = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // The held packet is never overwritten; a late byte is dropped and flagged.
        if (rx_done) begin
          err_hit[E_OVR] = 1'b1;
        end
        if (pkt_ready) begin
          state_next   = S_IDLE;
          pkt_len_next = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Inter-byte watchdog; a byte landing on the final cycle still wins.
    if (in_frame && !rx_done) begin
      if (cnt_reg == CNT_LAST) begin
        err_hit[E_TO] = 1'b1;
        state_next    = S_IDLE;
      end else begin
        cnt_next = cnt_reg + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      len_reg       <= '0;
      idx_reg       <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      pkt_len_reg   <= '0;
      rx_en_reg     <= 1'b0;
      pkt_valid_reg <= 1'b0;
      err_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      idx_reg       <= idx_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      pkt_len_reg   <= pkt_len_next;
      rx_en_reg     <= (state_next != S_HOLD);
      pkt_valid_reg <= (state_next == S_HOLD);
      err_reg       <= err_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pay_mem[idx_reg[AW-1:0]] <= rx_data;
    end
  end

  // pkt_len is zero outside HOLD, so this also blanks rd_data while no packet is held.
  assign rd_data = (32'(rd_addr) < 32'(pkt_len_reg)) ? pay_mem[rd_addr] : '0;

  assign rx_en       = rx_en_reg;
  assign pkt_valid   = pkt_valid_reg;
  assign pkt_len     = pkt_len_reg;
  assign err_chk     = err_reg[E_CHK];
  assign err_len     = err_reg[E_LEN];
  assign err_timeout = err_reg[E_TO];
  assign err_ovr     = err_reg[E_OVR];

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: stimulus pushes expected events, a monitor
// pops and compares whenever the DUT raises a packet or an error pulse.
`timescale 1ns/100ps
module tb_uart_rx_pkt_ctrl;

  localparam int         SIZE    = 8;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 40;
  localparam int         AW      = 4;
  localparam logic [7:0] SOF     = 8'hA5;

  localparam int K_PKT = 0;
  localparam int K_CHK = 1;
  localparam int K_LEN = 2;
  localparam int K_TO  = 3;
  localparam int K_OVR = 4;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          rx_done   = 1'b0;
  logic [7:0]    rx_data   = 8'h00;
  logic          pkt_ready = 1'b0;
  logic [AW-1:0] rd_addr   = '0;
  logic          rx_en;
  logic          pkt_valid;
  logic [7:0]    pkt_len;
  logic [7:0]    rd_data;
  logic          err_chk;
  logic          err_len;
  logic          err_timeout;
  logic          err_ovr;

  typedef struct packed {
    logic [2:0]   kind;
    logic [7:0]   len;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  bit   pkt_checked = 1'b0;

  uart_rx_pkt_ctrl #(
    .SIZE   (SIZE),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT(TIMEOUT),
    .SOF    (SOF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .rx_en      (rx_en),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_len    (pkt_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_timeout(err_timeout),
    .err_ovr    (err_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int kind, input logic [7:0] len, input logic [127:0] data);
    exp_t e;
    e.kind = 3'(kind);
    e.len  = len;
    e.data = data;
    return e;
  endfunction

  // Reference checksum: LEN xor every payload byte.
  function automatic logic [7:0] xor_chk(input logic [7:0] len, input logic [127:0] data);
    logic [7:0] x;
    x = len;
    for (int i = 0; i < int'(len); i++) x ^= data[i*8 +: 8];
    return x;
  endfunction

  function automatic int rand_gap();
    if ($urandom_range(0, 9) == 0) return TIMEOUT - 1;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic consume(input int kind, output exp_t e);
    e = '0;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual_kind=%0d required=no_event @%0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
    end
  endtask

  // Monitor: pops one expectation per error pulse cycle and per packet presentation.
  initial begin : monitor
    bit         prev_valid;
    exp_t       e;
    logic [3:0] errs;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        errs = {err_ovr, err_timeout, err_len, err_chk};
        for (int k = 0; k < 4; k++) begin
          if (errs[k]) consume(k + 1, e);
        end
        if (pkt_valid && !prev_valid) begin
          consume(K_PKT, e);
          check("pkt_len", 32'(pkt_len), 32'(e.len));
          check("rx_en_in_hold", 32'(rx_en), 32'd0);
          for (int i = 0; i < MAX_LEN; i++) begin
            rd_addr = AW'(i);
            #0.2;
            check($sformatf("rd_data[%0d]", i), 32'(rd_data),
                  32'((i < int'(e.len)) ? e.data[i*8 +: 8] : 8'h00));
          end
          pkt_checked = 1'b1;
        end
        prev_valid = pkt_valid;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_head(input logic [7:0] len, input logic [127:0] data, input int nbytes, input bit fast);
    send_byte(SOF, fast ? 0 : rand_gap());
    send_byte(len, fast ? 0 : rand_gap());
    for (int i = 0; i < nbytes; i++) send_byte(data[i*8 +: 8], fast ? 0 : rand_gap());
  endtask

  task automatic host_accept(input int mode, input logic [7:0] len, input logic [127:0] data);
    int n;
    n = 0;
    while (!pkt_checked && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pkt_presented", 32'(pkt_checked), 32'd1);
    if (!pkt_checked) return;
    pkt_checked = 1'b0;
    if (mode == 1) begin
      exp_q.push_back(mk(K_OVR, 8'd0, '0));
      rx_done = 1'b1;
      rx_data = 8'h55;
      @(negedge clk);
      rx_done = 1'b0;
      check("ovr_keeps_valid", 32'(pkt_valid), 32'd1);
      check("ovr_keeps_len", 32'(pkt_len), 32'(len));
      for (int i = 0; i < int'(len); i++) begin
        rd_addr = AW'(i);
        #0.2;
        check($sformatf("ovr_buf[%0d]", i), 32'(rd_data), 32'(data[i*8 +: 8]));
      end
    end
    pkt_ready = 1'b1;
    if (mode == 2) begin
      exp_q.push_back(mk(K_OVR, 8'd0, '0));
      rx_done = 1'b1;
      rx_data = 8'h55;
    end
    @(negedge clk);
    pkt_ready = 1'b0;
    rx_done   = 1'b0;
    check("valid_drop_after_ready", 32'(pkt_valid), 32'd0);
    check("rx_en_after_ready", 32'(rx_en), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    rd_addr = '0;
    #0.5;
    check({tag, "_rx_en"}, 32'(rx_en), 32'd0);
    check({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
    check({tag, "_pkt_len"}, 32'(pkt_len), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_errs"}, 32'({err_chk, err_len, err_timeout, err_ovr}), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    check("rx_en_low_until_edge", 32'(rx_en), 32'd0);
    @(negedge clk);
    check("rx_en_rises_after_rst", 32'(rx_en), 32'd1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=timeout required=finish checks=%0d", checks);
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    logic [127:0] data;
    logic [7:0]   len;
    logic [7:0]   b;
    int           kind;
    int           stage;

    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    release_reset();

    // 1: basic good frame with fixed latency
    data = {104'h0, 8'h33, 8'h22, 8'h11};
    exp_q.push_back(mk(K_PKT, 8'd3, data));
    send_head(8'd3, data, 3, 1'b1);
    send_byte(8'h03, 0);
    check("valid_latency", 32'(pkt_valid), 32'd1);
    check("rx_en_hold", 32'(rx_en), 32'd0);
    host_accept(0, 8'd3, data);
    $display("txn directed good_frame len=3");

    // 2: bad checksum then a good frame
    exp_q.push_back(mk(K_CHK, 8'd0, '0));
    send_head(8'd3, data, 3, 1'b1);
    send_byte(8'h04, 0);
    exp_q.push_back(mk(K_PKT, 8'd3, data));
    send_head(8'd3, data, 3, 1'b1);
    send_byte(8'h03, 0);
    host_accept(0, 8'd3, data);
    $display("txn directed bad_chk_then_good");

    // 3: illegal lengths, then the maximum length
    exp_q.push_back(mk(K_LEN, 8'd0, '0));
    send_byte(SOF, 0);
    send_byte(8'd0, 0);
    exp_q.push_back(mk(K_LEN, 8'd0, '0));
    send_byte(SOF, 0);
    send_byte(8'd17, 0);
    data = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(mk(K_PKT, 8'd16, data));
    send_head(8'd16, data, 16, 1'b1);
    send_byte(xor_chk(8'd16, data), 0);
    host_accept(0, 8'd16, data);
    $display("txn directed len_bounds");

    // 4: timeout after exact silence, then last-cycle bytes that must not time out
    data = {120'h0, 8'h11};
    exp_q.push_back(mk(K_TO, 8'd0, '0));
    send_head(8'd2, data, 1, 1'b1);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("timeout_not_early", 32'(err_timeout), 32'd0);
    @(negedge clk);
    check("timeout_fires", 32'(err_timeout), 32'd1);
    @(negedge clk);
    check("timeout_single_pulse", 32'(err_timeout), 32'd0);
    data = {112'h0, 8'h22, 8'h11};
    exp_q.push_back(mk(K_PKT, 8'd2, data));
    send_head(8'd2, data, 1, 1'b1);
    send_byte(8'h22, TIMEOUT - 1);
    send_byte(8'h31, TIMEOUT - 1);
    host_accept(0, 8'd2, data);
    $display("txn directed timeout_boundary");

    // 5: overrun while held, without and with a same-cycle handshake
    data = {104'h0, 8'h33, 8'h22, 8'h11};
    exp_q.push_back(mk(K_PKT, 8'd3, data));
    send_head(8'd3, data, 3, 1'b1);
    send_byte(8'h03, 0);
    host_accept(1, 8'd3, data);
    exp_q.push_back(mk(K_PKT, 8'd3, data));
    send_head(8'd3, data, 3, 1'b1);
    send_byte(8'h03, 0);
    host_accept(2, 8'd3, data);
    $display("txn directed overrun");

    // 6: asynchronous reset mid-payload and while holding
    send_head(8'd5, data, 2, 1'b1);
    #2 rst = 1'b1;
    check_zero("rst_mid_payload");
    release_reset();
    exp_q.push_back(mk(K_PKT, 8'd3, data));
    send_head(8'd3, data, 3, 1'b1);
    send_byte(8'h03, 0);
    for (int n = 0; n < 50 && !pkt_checked; n++) @(negedge clk);
    check("hold_before_rst", 32'(pkt_checked), 32'd1);
    pkt_checked = 1'b0;
    #2 rst = 1'b1;
    check_zero("rst_in_hold");
    release_reset();
    exp_q.push_back(mk(K_PKT, 8'd3, data));
    send_head(8'd3, data, 3, 1'b1);
    send_byte(8'h03, 0);
    host_accept(0, 8'd3, data);
    $display("txn directed async_reset");

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 5));
      len  = 8'($urandom_range(1, MAX_LEN));
      data = '0;
      for (int i = 0; i < int'(len); i++) data[i*8 +: 8] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) data[7:0] = SOF;
      case (kind)
        0, 1: begin
          exp_q.push_back(mk(K_PKT, len, data));
          send_head(len, data, int'(len), 1'b0);
          send_byte(xor_chk(len, data), rand_gap());
          stage = int'($urandom_range(0, 2));
          host_accept(stage, len, data);
          $display("txn %0d good len=%0d host_mode=%0d", t, len, stage);
        end
        2: begin
          exp_q.push_back(mk(K_CHK, 8'd0, '0));
          send_head(len, data, int'(len), 1'b0);
          send_byte(xor_chk(len, data) ^ 8'($urandom_range(1, 255)), rand_gap());
          $display("txn %0d bad_chk len=%0d", t, len);
        end
        3: begin
          b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
          exp_q.push_back(mk(K_LEN, 8'd0, '0));
          send_byte(SOF, rand_gap());
          send_byte(b, rand_gap());
          $display("txn %0d bad_len len=%0d", t, b);
        end
        4: begin
          stage = int'($urandom_range(0, int'(len) + 1));
          exp_q.push_back(mk(K_TO, 8'd0, '0));
          send_byte(SOF, rand_gap());
          if (stage > 0) send_byte(len, rand_gap());
          for (int i = 0; i < stage - 1; i++) send_byte(data[i*8 +: 8], rand_gap());
          repeat (TIMEOUT + 1) @(negedge clk);
          $display("txn %0d timeout stage=%0d len=%0d", t, stage, len);
        end
        default: begin
          do b = 8'($urandom); while (b == SOF);
          send_byte(b, rand_gap());
          $display("txn %0d junk byte=0x%02h", t, b);
        end
      endcase
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
